// File: rtl/rat_int_pkg.sv
// Shared sizes and types for the integer rename map.
package rat_int_pkg;

    localparam int unsigned RENAME_WIDTH       = 4;
    localparam int unsigned COMMIT_WIDTH       = 4;
    localparam int unsigned ARF_INT_SIZE       = 32;
    localparam int unsigned PRF_INT_SIZE       = 64;
    localparam int unsigned ARF_INT_INDEX_SIZE = $clog2(ARF_INT_SIZE);
    localparam int unsigned PRF_INT_INDEX_SIZE = $clog2(PRF_INT_SIZE);
    localparam int unsigned SLOT_INDEX_SIZE    = $clog2(RENAME_WIDTH);

    typedef logic [ARF_INT_INDEX_SIZE-1:0] arch_reg_t;
    typedef logic [PRF_INT_INDEX_SIZE-1:0] prf_idx_t;
    typedef logic [SLOT_INDEX_SIZE-1:0]    slot_idx_t;

    // Intra-group forwarding select: take prf_in[slot] instead of the map when hit is set.
    typedef struct packed {
        logic      hit;
        slot_idx_t slot;
    } byp_sel_t;

endpackage

// File: rtl/rat_int_if.sv
// Rename-stage bundle: upstream group, free-list handshake, retire port and renamed outputs.
interface rat_int_if;
    import rat_int_pkg::*;

    logic                                  stall;
    logic                                  recover;
    logic [RENAME_WIDTH-1:0]               in_valid;
    arch_reg_t [RENAME_WIDTH-1:0]          rs1;
    arch_reg_t [RENAME_WIDTH-1:0]          rs2;
    arch_reg_t [RENAME_WIDTH-1:0]          rd;
    logic [RENAME_WIDTH-1:0]               rd_valid;
    logic [RENAME_WIDTH-1:0]               prf_req;
    prf_idx_t [RENAME_WIDTH-1:0]           prf_in;
    logic                                  allocatable;
    logic                                  ready;
    logic [RENAME_WIDTH-1:0]               out_valid;
    prf_idx_t [RENAME_WIDTH-1:0]           prs1;
    prf_idx_t [RENAME_WIDTH-1:0]           prs2;
    prf_idx_t [RENAME_WIDTH-1:0]           prd;
    prf_idx_t [RENAME_WIDTH-1:0]           prd_old;
    logic [COMMIT_WIDTH-1:0]               commit_valid;
    arch_reg_t [COMMIT_WIDTH-1:0]          commit_rd;
    prf_idx_t [COMMIT_WIDTH-1:0]           commit_prd;

    modport master (
        output stall, recover, in_valid, rs1, rs2, rd, rd_valid, prf_in, allocatable,
        output commit_valid, commit_rd, commit_prd,
        input  prf_req, ready, out_valid, prs1, prs2, prd, prd_old
    );

    modport slave (
        input  stall, recover, in_valid, rs1, rs2, rd, rd_valid, prf_in, allocatable,
        input  commit_valid, commit_rd, commit_prd,
        output prf_req, ready, out_valid, prs1, prs2, prd, prd_old
    );

endinterface

// File: rtl/rat_int_bypass.sv
// Intra-group dependency check: for each slot, finds the youngest earlier slot that
// allocates the register being read (rs1/rs2) or overwritten (rd).
module rat_int_bypass
    import rat_int_pkg::*;
(
    input  arch_reg_t [RENAME_WIDTH-1:0] rs1,
    input  arch_reg_t [RENAME_WIDTH-1:0] rs2,
    input  arch_reg_t [RENAME_WIDTH-1:0] rd,
    input  logic [RENAME_WIDTH-1:0]      alloc,
    output byp_sel_t [RENAME_WIDTH-1:0]  rs1_sel,
    output byp_sel_t [RENAME_WIDTH-1:0]  rs2_sel,
    output byp_sel_t [RENAME_WIDTH-1:0]  rd_sel
);

    // Ascending scan so the youngest matching earlier slot overwrites older matches.
    // alloc implies rd != 0, so x0 never hits.
    always_comb begin
        rs1_sel = '0;
        rs2_sel = '0;
        rd_sel  = '0;
        for (int i = 1; i < RENAME_WIDTH; i++) begin
            for (int j = 0; j < i; j++) begin
                if (alloc[j]) begin
                    if (rd[j] == rs1[i]) rs1_sel[i] = '{hit: 1'b1, slot: slot_idx_t'(j)};
                    if (rd[j] == rs2[i]) rs2_sel[i] = '{hit: 1'b1, slot: slot_idx_t'(j)};
                    if (rd[j] == rd[i])  rd_sel[i]  = '{hit: 1'b1, slot: slot_idx_t'(j)};
                end
            end
        end
    end

endmodule

// File: rtl/rat_int.sv
// Integer register alias table: speculative map for rename, committed map for recovery.
module rat_int
    import rat_int_pkg::*;
(
    input logic       clock,
    input logic       reset,
    rat_int_if.slave  rif
);

    prf_idx_t spec_q [ARF_INT_SIZE];
    prf_idx_t spec_wr [ARF_INT_SIZE];
    prf_idx_t committed_q [ARF_INT_SIZE];
    prf_idx_t committed_d [ARF_INT_SIZE];

    logic [RENAME_WIDTH-1:0]     out_valid_q;
    prf_idx_t [RENAME_WIDTH-1:0] prs1_q, prs2_q, prd_q, prd_old_q;
    prf_idx_t [RENAME_WIDTH-1:0] prs1_d, prs2_d, prd_d, prd_old_d;

    logic [RENAME_WIDTH-1:0]     alloc;
    byp_sel_t [RENAME_WIDTH-1:0] rs1_sel, rs2_sel, rd_sel;
    logic                        accept;

    // Slots that need a fresh physical register; x0 is never renamed.
    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            alloc[i] = rif.in_valid[i] & rif.rd_valid[i] & (rif.rd[i] != '0);
        end
    end

    assign accept      = (|rif.in_valid) & rif.allocatable & ~rif.stall & ~rif.recover;
    assign rif.ready   = accept;
    assign rif.prf_req = alloc & {RENAME_WIDTH{~rif.stall & ~rif.recover}};

    rat_int_bypass u_bypass (
        .rs1     (rif.rs1),
        .rs2     (rif.rs2),
        .rd      (rif.rd),
        .alloc   (alloc),
        .rs1_sel (rs1_sel),
        .rs2_sel (rs2_sel),
        .rd_sel  (rd_sel)
    );

    // Per-slot translation: forwarded new prd from an earlier slot beats the map.
    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (rif.rs1[i] == '0)   prs1_d[i] = '0;
            else if (rs1_sel[i].hit) prs1_d[i] = rif.prf_in[rs1_sel[i].slot];
            else                     prs1_d[i] = spec_q[rif.rs1[i]];
            if (rif.rs2[i] == '0)   prs2_d[i] = '0;
            else if (rs2_sel[i].hit) prs2_d[i] = rif.prf_in[rs2_sel[i].slot];
            else                     prs2_d[i] = spec_q[rif.rs2[i]];
            prd_d[i]     = alloc[i] ? rif.prf_in[i] : '0;
            prd_old_d[i] = '0;
            if (alloc[i]) begin
                prd_old_d[i] = rd_sel[i].hit ? rif.prf_in[rd_sel[i].slot] : spec_q[rif.rd[i]];
            end
        end
    end

    // Speculative map after this group; later slots overwrite earlier ones on equal rd.
    always_comb begin
        spec_wr = spec_q;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (alloc[i]) spec_wr[rif.rd[i]] = rif.prf_in[i];
        end
    end

    // Committed map after this cycle's retires; higher slot wins on equal rd.
    always_comb begin
        committed_d = committed_q;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (rif.commit_valid[k] && rif.commit_rd[k] != '0) begin
                committed_d[rif.commit_rd[k]] = rif.commit_prd[k];
            end
        end
    end

    // Map and output registers: reset > recover > stall > accept.
    always_ff @(posedge clock) begin
        if (!reset) begin
            spec_q      <= '{default: '0};
            committed_q <= '{default: '0};
            out_valid_q <= '0;
            prs1_q      <= '0;
            prs2_q      <= '0;
            prd_q       <= '0;
            prd_old_q   <= '0;
        end else begin
            committed_q <= committed_d;
            if (rif.recover) begin
                spec_q      <= committed_d;
                out_valid_q <= '0;
            end else if (!rif.stall) begin
                if (accept) begin
                    spec_q      <= spec_wr;
                    out_valid_q <= rif.in_valid;
                    prs1_q      <= prs1_d;
                    prs2_q      <= prs2_d;
                    prd_q       <= prd_d;
                    prd_old_q   <= prd_old_d;
                end else begin
                    out_valid_q <= '0;
                end
            end
        end
    end

    assign rif.out_valid = out_valid_q;
    assign rif.prs1      = prs1_q;
    assign rif.prs2      = prs2_q;
    assign rif.prd       = prd_q;
    assign rif.prd_old   = prd_old_q;

endmodule

// File: tb/tb_rat_int.sv
// Self-checking bench for rat_int: directed scenarios followed by random traffic,
// all checked against a sequential slot-by-slot model of the rename map.
module tb_rat_int;
    import rat_int_pkg::*;

    logic clock;
    logic reset;
    rat_int_if rif ();

    rat_int dut (
        .clock (clock),
        .reset (reset),
        .rif   (rif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference state
    int m_spec [ARF_INT_SIZE];
    int m_comm [ARF_INT_SIZE];
    logic [RENAME_WIDTH-1:0] e_ov;
    int e_prs1 [RENAME_WIDTH];
    int e_prs2 [RENAME_WIDTH];
    int e_prd [RENAME_WIDTH];
    int e_old [RENAME_WIDTH];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        rif.stall        = 1'b0;
        rif.recover      = 1'b0;
        rif.in_valid     = '0;
        rif.rs1          = '0;
        rif.rs2          = '0;
        rif.rd           = '0;
        rif.rd_valid     = '0;
        rif.prf_in       = '0;
        rif.allocatable  = 1'b1;
        rif.commit_valid = '0;
        rif.commit_rd    = '0;
        rif.commit_prd   = '0;
    endtask

    task automatic set_slot(input int i, input int s1, input int s2, input int d,
                            input bit dv, input int p);
        rif.in_valid[i] = 1'b1;
        rif.rs1[i]      = arch_reg_t'(s1);
        rif.rs2[i]      = arch_reg_t'(s2);
        rif.rd[i]       = arch_reg_t'(d);
        rif.rd_valid[i] = dv;
        rif.prf_in[i]   = prf_idx_t'(p);
    endtask

    task automatic model_reset();
        for (int r = 0; r < ARF_INT_SIZE; r++) begin
            m_spec[r] = 0;
            m_comm[r] = 0;
        end
        e_ov = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        int t [ARF_INT_SIZE];
        logic [RENAME_WIDTH-1:0] need;
        logic exp_ready;
        int p1 [RENAME_WIDTH];
        int p2 [RENAME_WIDTH];
        int pd [RENAME_WIDTH];
        int po [RENAME_WIDTH];
        #1;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            need[i] = rif.in_valid[i] && rif.rd_valid[i] && (rif.rd[i] != 0);
        end
        exp_ready = (rif.in_valid != 0) && rif.allocatable && !rif.stall && !rif.recover;
        chk("prf_req", int'(rif.prf_req),
            int'((rif.stall || rif.recover) ? 4'b0 : need));
        chk("ready", int'(rif.ready), int'(exp_ready));
        // Rename slots one after another against a scratch copy of the map.
        t = m_spec;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            p1[i] = (rif.rs1[i] == 0) ? 0 : t[rif.rs1[i]];
            p2[i] = (rif.rs2[i] == 0) ? 0 : t[rif.rs2[i]];
            pd[i] = 0;
            po[i] = 0;
            if (need[i]) begin
                po[i] = t[rif.rd[i]];
                pd[i] = int'(rif.prf_in[i]);
                t[rif.rd[i]] = pd[i];
            end
        end
        if (!reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (rif.commit_valid[k] && rif.commit_rd[k] != 0) begin
                    m_comm[rif.commit_rd[k]] = int'(rif.commit_prd[k]);
                end
            end
            if (rif.recover) begin
                m_spec = m_comm;
                e_ov   = '0;
            end else if (!rif.stall) begin
                if (exp_ready) begin
                    m_spec = t;
                    e_ov   = rif.in_valid;
                    e_prs1 = p1;
                    e_prs2 = p2;
                    e_prd  = pd;
                    e_old  = po;
                end else begin
                    e_ov = '0;
                end
            end
        end
        tick();
        chk("out_valid", int'(rif.out_valid), int'(e_ov));
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (e_ov[i]) begin
                chk($sformatf("prs1[%0d]", i), int'(rif.prs1[i]), e_prs1[i]);
                chk($sformatf("prs2[%0d]", i), int'(rif.prs2[i]), e_prs2[i]);
                chk($sformatf("prd[%0d]", i), int'(rif.prd[i]), e_prd[i]);
                chk($sformatf("prd_old[%0d]", i), int'(rif.prd_old[i]), e_old[i]);
            end
        end
    endtask

    initial begin
        clr();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        chk("reset out_valid", int'(rif.out_valid), 0);
        chk("reset prs1", int'(rif.prs1), 0);
        chk("reset prs2", int'(rif.prs2), 0);
        chk("reset prd", int'(rif.prd), 0);
        chk("reset prd_old", int'(rif.prd_old), 0);
        reset = 1'b1;

        // First rename out of reset: every source maps to p0.
        clr();
        set_slot(0, 5, 6, 7, 1'b1, 1);
        step();
        chk("t1 prd", int'(rif.prd[0]), 1);
        chk("t1 out_valid", int'(rif.out_valid), 4'b0001);

        // RAW and WAW inside one group.
        clr();
        set_slot(0, 0, 0, 3, 1'b1, 4);
        set_slot(1, 3, 0, 3, 1'b1, 5);
        set_slot(2, 0, 3, 0, 1'b0, 6);
        step();
        chk("t2 prs1[1]", int'(rif.prs1[1]), 4);
        chk("t2 prd_old[1]", int'(rif.prd_old[1]), 4);
        chk("t2 prs2[2]", int'(rif.prs2[2]), 5);

        // Free list empty, then available with the same group held.
        clr();
        for (int i = 0; i < RENAME_WIDTH; i++) set_slot(i, i + 1, 3, 8 + i, 1'b1, 10 + i);
        rif.allocatable = 1'b0;
        step();
        rif.allocatable = 1'b1;
        step();

        // Stall holds outputs; commit still lands in the committed map.
        for (int c = 0; c < 3; c++) begin
            rif.stall = 1'b1;
            rif.commit_valid = '0;
            if (c == 0) begin
                rif.commit_valid[0] = 1'b1;
                rif.commit_rd[0]    = 5'd3;
                rif.commit_prd[0]   = 6'd4;
            end
            step();
            chk("stall hold prd[0]", int'(rif.prd[0]), 10);
        end

        // Speculative x3->p9, then recover back to committed x3->p4.
        clr();
        set_slot(0, 0, 0, 3, 1'b1, 9);
        step();
        clr();
        rif.recover = 1'b1;
        step();
        clr();
        set_slot(0, 3, 0, 0, 1'b0, 0);
        step();
        chk("t5 prs1 after recover", int'(rif.prs1[0]), 4);

        // rd=x0 is not renamed; duplicate commit rd keeps the higher slot.
        clr();
        set_slot(0, 0, 0, 0, 1'b1, 33);
        rif.commit_valid = 4'b0101;
        rif.commit_rd[0] = 5'd10;
        rif.commit_prd[0] = 6'd20;
        rif.commit_rd[2] = 5'd10;
        rif.commit_prd[2] = 6'd30;
        step();
        chk("t6 prd x0", int'(rif.prd[0]), 0);
        clr();
        rif.recover = 1'b1;
        step();
        clr();
        set_slot(0, 10, 0, 0, 1'b0, 0);
        step();
        chk("t6 commit order", int'(rif.prs1[0]), 30);

        // Random traffic; small register range to provoke dependencies.
        for (int n = 0; n < 400; n++) begin
            clr();
            reset = ($urandom_range(0, 99) != 0);
            rif.stall       = ($urandom_range(0, 99) < 15);
            rif.recover     = ($urandom_range(0, 99) < 8);
            rif.allocatable = ($urandom_range(0, 99) < 85);
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                rif.in_valid[i] = ($urandom_range(0, 99) < 80);
                rif.rs1[i]      = arch_reg_t'($urandom_range(0, 7));
                rif.rs2[i]      = arch_reg_t'($urandom_range(0, 7));
                rif.rd[i]       = arch_reg_t'($urandom_range(0, 7));
                rif.rd_valid[i] = ($urandom_range(0, 99) < 75);
                rif.prf_in[i]   = prf_idx_t'($urandom_range(1, 63));
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                rif.commit_valid[k] = ($urandom_range(0, 99) < 40);
                rif.commit_rd[k]    = arch_reg_t'($urandom_range(0, 7));
                rif.commit_prd[k]   = prf_idx_t'($urandom_range(1, 63));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
